// File: rtl/sll_pipe_pkg.sv
// Shared constants and the per-stage payload type for the pipelined left shifter.
package sll_pipe_pkg;

  localparam int WIDTH    = 16;
  localparam int CNT_W    = 4;
  localparam int N_STAGES = CNT_W;

  // Everything a stage carries forward besides its valid bit.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             rot;
  } stage_t;

endpackage

// File: rtl/sll_stage.sv
// One registered stage of the left shifter: shifts (or rotates, when
// SLL_PIPE_ROTATE_EN is defined) by SHAMT = 2^STAGE if cnt[STAGE] is set.
module sll_stage
  import sll_pipe_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   up_valid,
  output logic   up_ready,
  input  stage_t up,
  output logic   dn_valid,
  input  logic   dn_ready,
  output stage_t dn
);

  localparam int SHAMT = 1 << STAGE;

  stage_t nxt;

  // Shift the incoming payload by this stage's power of two.
  always_comb begin
    // NOTE: full default first so no path leaves nxt unassigned (no latch).
    nxt = up;
    if (up.cnt[STAGE]) begin
`ifdef SLL_PIPE_ROTATE_EN
      if (up.rot) nxt.data = (up.data << SHAMT) | (up.data >> (WIDTH - SHAMT));
      else        nxt.data = up.data << SHAMT;
`else
      nxt.data = up.data << SHAMT;
`endif
    end
  end

  // Accept when empty or when the contents move on this edge.
  assign up_ready = !dn_valid || dn_ready;

  // Stage register: valid bit plus payload, loaded only on a real transfer.
  always_ff @(posedge clk) begin
    // NOTE: payload is reset too, so the last stage presents out=0 after reset.
    if (rst) begin
      // NOTE: non-blocking for all state so stages update in lockstep.
      dn_valid <= 1'b0;
      dn       <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn <= nxt;
    end
  end

endmodule

// File: rtl/sll_pipe.sv
// Pipelined 16-bit logical left shifter, one stage per count bit, with
// valid/ready handshakes on both sides. Optional rotate-left via the
// SLL_PIPE_ROTATE_EN macro; without it rot is ignored.
module sll_pipe
  import sll_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  // Index 0 is the input port, index N_STAGES the output port.
  stage_t pl  [N_STAGES+1];
  logic   vld [N_STAGES+1];
  logic   rdy [N_STAGES+1];
  logic   rot_eff;

`ifdef SLL_PIPE_ROTATE_EN
  assign rot_eff = rot;
`else
  logic unused_rot;
  assign rot_eff    = 1'b0;
  assign unused_rot = rot;
`endif

  assign vld[0]        = in_valid;
  assign pl[0]         = {in, cnt, rot_eff};
  assign in_ready      = rdy[0];
  assign rdy[N_STAGES] = out_ready;

  genvar k;
  generate
    for (k = 0; k < N_STAGES; k++) begin : g_stage
      sll_stage #(.STAGE(k)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (vld[k]),
        .up_ready (rdy[k]),
        .up       (pl[k]),
        .dn_valid (vld[k+1]),
        .dn_ready (rdy[k+1]),
        .dn       (pl[k+1])
      );
    end
  endgenerate

  assign out_valid = vld[N_STAGES];
  assign out       = pl[N_STAGES].data;

  // Count and rot have no meaning once the last stage has applied them.
  logic unused_tail;
  assign unused_tail = ^{pl[N_STAGES].cnt, pl[N_STAGES].rot};

endmodule

// File: tb/tb_sll_pipe.sv
// Directed testbench for sll_pipe; expectations follow the build's
// SLL_PIPE_ROTATE_EN setting.
module tb_sll_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  cnt;
  logic        rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  sll_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .cnt       (cnt),
    .rot       (rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data)
  );

  always #5 clk = ~clk;

  // Present one operation on an empty pipe and wait for its result.
  // lat counts edges from the accepting edge (=1) to out_valid.
  task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic r,
                       output logic [15:0] res, output int lat);
    in_data = d; cnt = c; rot = r; in_valid = 1'b1; out_ready = 1'b1;
    lat = 99; res = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = n; res = out_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; cnt = '0; rot = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] v_in  [3] = '{16'h0001, 16'hABCD, 16'h1234};
    logic [3:0]  v_cnt [3] = '{4'd15, 4'd4, 4'd0};
    logic [15:0] v_exp [3] = '{16'h8000, 16'hBCD0, 16'h1234};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %b expected 1", i, in_ready); end
      issue(v_in[i], v_cnt[i], 1'b0, res, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (res !== v_exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, res, v_exp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int first = -1, last = -1, rx = 0;
    logic ready_ok = 1'b1;
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; in_data = 16'hFFFF; cnt = 4'(i); rot = 1'b0;
        if (in_ready !== 1'b1) ready_ok = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        exp = 16'hFFFF << rx;
        checks++; if (out_data !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", rx, out_data, exp); end
        if (first < 0) first = i;
        last = i;
        rx++;
      end
      @(posedge clk); #1;
    end
    checks++; if (first !== 4) begin errors++; $display("FAIL stream_first: got %0d expected 4", first); end
    checks++; if (last !== 19) begin errors++; $display("FAIL stream_last: got %0d expected 19", last); end
    checks++; if (rx !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", rx); end
    checks++; if (ready_ok !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b expected 1", ready_ok); end
  endtask

  task automatic test_back_pressure();
    logic [15:0] b_in  [6] = '{16'h1234, 16'h00FF, 16'h8421, 16'hF00F, 16'h0F0F, 16'hAAAA};
    logic [3:0]  b_cnt [6] = '{4'd4, 4'd8, 4'd1, 4'd12, 4'd3, 4'd0};
    logic [15:0] b_exp [6] = '{16'h2340, 16'hFF00, 16'h0842, 16'hF000, 16'h7878, 16'hAAAA};
    int sent = 0, rx = 0;
    logic acc, stable = 1'b1;
    out_ready = 1'b0; rot = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin in_data = b_in[sent]; cnt = b_cnt[sent]; end
      #1;
      acc = in_valid && in_ready;
      if (i >= 5 && (out_valid !== 1'b1 || out_data !== 16'h2340)) stable = 1'b0;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    checks++; if (sent !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_out_stable: got %b expected 1", stable); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
    for (int i = 0; i < 30; i++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin in_data = b_in[sent]; cnt = b_cnt[sent]; end
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (rx >= 6) begin
          errors++; $display("FAIL bp_extra: got output %h expected none", out_data);
        end else if (out_data !== b_exp[rx]) begin
          errors++; $display("FAIL bp_data[%0d]: got %h expected %h", rx, out_data, b_exp[rx]);
        end
        rx++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++; if (sent !== 6) begin errors++; $display("FAIL bp_sent: got %0d expected 6", sent); end
    checks++; if (rx !== 6) begin errors++; $display("FAIL bp_received: got %0d expected 6", rx); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    out_ready = 1'b1; rot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h00F0 + 16'(i); cnt = 4'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_out: got %h expected 0000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_stale: got %b expected 0", seen); end
  endtask

  task automatic test_rotate();
`ifdef SLL_PIPE_ROTATE_EN
    localparam int NV = 4;
    logic [15:0] r_in  [NV] = '{16'h8001, 16'hABCD, 16'h8001, 16'hABCD};
    logic [3:0]  r_cnt [NV] = '{4'd1, 4'd4, 4'd1, 4'd4};
    logic        r_rot [NV] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] r_exp [NV] = '{16'h0003, 16'hBCDA, 16'h0002, 16'hBCD0};
`else
    localparam int NV = 1;
    logic [15:0] r_in  [NV] = '{16'h8001};
    logic [3:0]  r_cnt [NV] = '{4'd1};
    logic        r_rot [NV] = '{1'b1};
    logic [15:0] r_exp [NV] = '{16'h0002};
`endif
    logic [15:0] res;
    int lat;
    for (int i = 0; i < NV; i++) begin
      issue(r_in[i], r_cnt[i], r_rot[i], res, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rot_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (res !== r_exp[i]) begin errors++; $display("FAIL rot_data[%0d]: got %h expected %h", i, res, r_exp[i]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_back_pressure();
    test_reset_mid();
    test_rotate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sll_pipe.md
Name: sll_pipe

Overview:
- Pipelined 16-bit logical left shifter, the opposite direction of the team's combinational logical right shifter.
- Uses one registered stage per count bit: stage k shifts by 2^k when cnt[k]=1.
- Valid/ready handshakes at input and output, so the execute-stage shift path can stall without losing operands.
- Full throughput of one operation per cycle when unstalled.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two.
- CNT_W, 4, shift-count width; equals log2(WIDTH); also the number of pipeline stages.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand presented this cycle
- in_ready  output  1  pipeline can accept operand this cycle
- in  input  WIDTH  data to shift
- cnt  input  CNT_W  shift amount, 0..WIDTH-1
- rot  input  1  rotate-left request; honoured only when SLL_PIPE_ROTATE_EN is defined
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result this cycle
- out  output  WIDTH  shifted result

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high; on reset all stage valid bits are cleared.
  - out_valid=0 and out=0 (the data register clears as well).
  - in_ready=1 on the first cycle after reset deasserts.
- Handshake: transfer occurs on the rising edge where valid && ready.
  - in, cnt and rot are sampled only on an input transfer.
  - out is held stable while out_valid=1 && out_ready=0.
- Stage registers: stage k (k=0..CNT_W-1) holds data, the remaining cnt bits, rot and a valid bit.
  - Stage k output = data << 2^k when cnt[k]=1, else data. Zeros fill from the LSB; bits shifted past the MSB are discarded.
  - The last stage drives out and out_valid directly.
- Advance rule: adv[k] = v[k+1]==0 || adv[k+1]; adv[last] = out_ready.
  - Stage k loads from stage k-1 when it is empty or advancing.
  - in_ready = !v[0] || adv[0]. This is a combinational ready chain; no bubbles are inserted.
- Latency: exactly CNT_W cycles from input transfer to out_valid=1 when unstalled. Back-to-back inputs give back-to-back outputs.
- Capacity: CNT_W entries. With out_ready held 0, in_ready drops after CNT_W transfers and rises again in the same cycle out_ready returns to 1.
- cnt=0: data passes unchanged with the same latency.
- Simultaneous input and output transfer while the pipe is full is legal; the occupancy count is unchanged.
- Ordering: results leave in strict acceptance order.
- Reset mid-operation: all in-flight operations are discarded with no output. No partial results are ever produced.

Optional Feature:
- Macro SLL_PIPE_ROTATE_EN.
- When defined: rot is carried through the stages. A stage with rot=1 and cnt[k]=1 performs rotate-left by 2^k (MSBs wrap into the LSBs). Full result: rotl(in, cnt).
- When undefined: rot is ignored and treated as 0; no rotate logic is synthesized. The port remains, so the port list is identical in both builds.

Decomposition:
- Package sll_pipe_pkg: WIDTH, CNT_W and stage-count constants, plus a stage payload typedef {data, cnt, rot}.
- Sub-module sll_stage: one registered stage, parameterized by its shift amount SHAMT = 2^k. It contains the valid/data registers and the local advance logic.
- sll_pipe instantiates CNT_W copies of sll_stage and wires the ready chain.

Test Plan:
- Basic shifts, out_ready=1:
  - in=0x0001, cnt=15 -> out=0x8000 after 4 cycles.
  - in=0xABCD, cnt=4 -> out=0xBCD0.
  - in=0x1234, cnt=0 -> out=0x1234.
- Streaming: 16 back-to-back inputs 0xFFFF with cnt=0..15 -> 16 consecutive outputs 0xFFFF, 0xFFFE, ..., 0x8000 with no gaps. First output appears 4 cycles after the first accept.
- Backpressure: out_ready=0 while 6 inputs are offered -> exactly 4 accepted, then in_ready=0.
  - out is held stable while stalled.
  - Raise out_ready -> the remaining inputs drain in order with no loss or duplication.
- Reset mid-flight: assert rst with 3 operations in flight -> next cycle out_valid=0, out=0, in_ready=1. No stale result emerges afterwards.
- Rotate build (SLL_PIPE_ROTATE_EN defined):
  - in=0x8001, cnt=1, rot=1 -> out=0x0003.
  - in=0xABCD, cnt=4, rot=1 -> out=0xBCDA.
  - Same inputs with rot=0 -> 0x0002 and 0xBCD0.
- Non-rotate build: in=0x8001, cnt=1, rot=1 -> out=0x0002 (rot ignored).
